cgra_config_sequencer: RTL and testbench



---
 rtl/cgra_pkg.sv | 26 ++
 rtl/cgra_config_sequencer_pe_context_counter.sv | 52 +++++
 rtl/cgra_config_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cgra_config_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA array sizing, derived index widths and sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cgra_pkg;

    localparam int CGRA_PE_ROW_SIZE          = 4;
    localparam int CGRA_PE_COLUMN_SIZE       = 4;
    localparam int CGRA_CONTEXT_SIZE         = 16;
    localparam int CGRA_DATA_WIDTH           = 32;
    localparam int CGRA_OPERATION_BIT_LENGTH = 4;
    localparam int CGRA_INPUT_NUM_BIT_LENGTH = 3;
    localparam int CGRA_EXEC_CYCLE_WIDTH     = 16;

    localparam int CGRA_PE_ROW_BIT_LENGTH       = $clog2(CGRA_PE_ROW_SIZE);
    localparam int CGRA_PE_COLUMN_BIT_LENGTH    = $clog2(CGRA_PE_COLUMN_SIZE);
    localparam int CGRA_CONTEXT_SIZE_BIT_LENGTH = $clog2(CGRA_CONTEXT_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cgra_config_sequencer_pe_context_counter.sv
// Nested write-position counter: column fastest, then row, then context slot.
// Latency: position advances on the edge after inc; last is combinational on the current position.
// Backpressure: none; holds while inc is low, clear has priority over inc.
module pe_context_counter
    import cgra_pkg::*;
#(
    parameter int ROWS  = CGRA_PE_ROW_SIZE,
    parameter int COLS  = CGRA_PE_COLUMN_SIZE,
    parameter int ROW_W = CGRA_PE_ROW_BIT_LENGTH,
    parameter int COL_W = CGRA_PE_COLUMN_BIT_LENGTH,
    parameter int CTX_W = CGRA_CONTEXT_SIZE_BIT_LENGTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CTX_W-1:0] max_id,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [CTX_W-1:0] ctx,
    output logic             last
);

    logic col_wrap;
    logic row_wrap;

    assign col_wrap = (col == COL_W'(COLS - 1));
    assign row_wrap = (row == ROW_W'(ROWS - 1));
    assign last     = col_wrap && row_wrap && (ctx == max_id);

    // Advance column, carry into row on column wrap, carry into context on row wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
            ctx <= '0;
        end else if (inc) begin
            if (col_wrap) begin
                col <= '0;
                if (row_wrap) begin
                    row <= '0;
                    ctx <= ctx + CTX_W'(1);
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/cgra_config_sequencer.sv
// Loads per-PE config words into the CGRA array, then pulses start_exec and times the run.
// Latency: write strobe 1 cycle after each handshake; start_exec 2 cycles after last handshake.
// Backpressure: cfg_ready high only while loading; cfg_valid low stalls with no writes.
module cgra_config_sequencer
    import cgra_pkg::*;
#(
    parameter int PE_ROW_SIZE             = CGRA_PE_ROW_SIZE,
    parameter int PE_COLUMN_SIZE          = CGRA_PE_COLUMN_SIZE,
    parameter int CONTEXT_SIZE            = CGRA_CONTEXT_SIZE,
    parameter int DATA_WIDTH              = CGRA_DATA_WIDTH,
    parameter int OPERATION_BIT_LENGTH    = CGRA_OPERATION_BIT_LENGTH,
    parameter int INPUT_NUM_BIT_LENGTH    = CGRA_INPUT_NUM_BIT_LENGTH,
    parameter int EXEC_CYCLE_WIDTH        = CGRA_EXEC_CYCLE_WIDTH,
    parameter int PE_ROW_BIT_LENGTH       = $clog2(PE_ROW_SIZE),
    parameter int PE_COLUMN_BIT_LENGTH    = $clog2(PE_COLUMN_SIZE),
    parameter int CONTEXT_SIZE_BIT_LENGTH = $clog2(CONTEXT_SIZE)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_start,
    // One extra bit so that out-of-range ids can be presented and rejected.
    input  logic [CONTEXT_SIZE_BIT_LENGTH:0]   context_max_id_in,
    input  logic [EXEC_CYCLE_WIDTH-1:0]        exec_cycles,
    input  logic                               abort,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_2,
    input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const,
    output logic [PE_ROW_BIT_LENGTH-1:0]       config_PE_row_index,
    output logic [PE_COLUMN_BIT_LENGTH-1:0]    config_PE_column_index,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic                               write_config_data,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    localparam logic [CONTEXT_SIZE_BIT_LENGTH:0] CTX_LIMIT =
        (CONTEXT_SIZE_BIT_LENGTH + 1)'(CONTEXT_SIZE);

    seq_state_t                         state;
    logic [EXEC_CYCLE_WIDTH-1:0]        run_len;
    logic [EXEC_CYCLE_WIDTH-1:0]        run_cnt;
    logic [PE_ROW_BIT_LENGTH-1:0]       pos_row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    pos_col;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] pos_ctx;
    logic                               pos_last;
    logic                               id_ok;
    logic                               accept;
    logic                               hs;

    assign id_ok  = (context_max_id_in < CTX_LIMIT);
    assign accept = (state == S_IDLE) && load_start && id_ok && !abort;
    assign hs     = (state == S_LOAD) && cfg_valid && cfg_ready && !abort;

    pe_context_counter #(
        .ROWS  (PE_ROW_SIZE),
        .COLS  (PE_COLUMN_SIZE),
        .ROW_W (PE_ROW_BIT_LENGTH),
        .COL_W (PE_COLUMN_BIT_LENGTH),
        .CTX_W (CONTEXT_SIZE_BIT_LENGTH)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .inc    (hs),
        .max_id (mapping_context_max_id),
        .row    (pos_row),
        .col    (pos_col),
        .ctx    (pos_ctx),
        .last   (pos_last)
    );

    // Sequencer FSM with all host/array outputs registered; abort overrides every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= S_IDLE;
            run_len                 <= '0;
            run_cnt                 <= '0;
            cfg_ready               <= 1'b0;
            config_PE_row_index     <= '0;
            config_PE_column_index  <= '0;
            config_index            <= '0;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_op               <= '0;
            config_const_data       <= '0;
            write_config_data       <= 1'b0;
            start_exec              <= 1'b0;
            mapping_context_max_id  <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            error                   <= 1'b0;
        end else begin
            write_config_data <= 1'b0;
            start_exec        <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                cfg_ready <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // busy lingers through the done cycle, dropping one cycle later
                        busy <= 1'b0;
                        if (load_start) begin
                            if (!id_ok) begin
                                error <= 1'b1;
                            end else begin
                                mapping_context_max_id <= context_max_id_in[CONTEXT_SIZE_BIT_LENGTH-1:0];
                                run_len   <= (exec_cycles == '0) ? EXEC_CYCLE_WIDTH'(1) : exec_cycles;
                                state     <= S_LOAD;
                                cfg_ready <= 1'b1;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (hs) begin
                            write_config_data       <= 1'b1;
                            config_PE_row_index     <= pos_row;
                            config_PE_column_index  <= pos_col;
                            config_index            <= pos_ctx;
                            config_input_PE_index_1 <= cfg_input_index_1;
                            config_input_PE_index_2 <= cfg_input_index_2;
                            config_op               <= cfg_op;
                            config_const_data       <= cfg_const;
                            if (pos_last) begin
                                state     <= S_START;
                                cfg_ready <= 1'b0;
                            end
                        end
                    end
                    S_START: begin
                        start_exec <= 1'b1;
                        run_cnt    <= run_len;
                        state      <= S_RUN;
                    end
                    S_RUN: begin
                        if (run_cnt <= EXEC_CYCLE_WIDTH'(1)) begin
                            state <= S_DONE;
                        end else begin
                            run_cnt <= run_cnt - EXEC_CYCLE_WIDTH'(1);
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Randomized bench: transaction-level model of word placement and pulse timing vs. observed events.
// Latency: n/a.
// Backpressure: drives cfg_valid in always-on, toggling and random patterns.
module tb_cgra_config_sequencer;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CW    = 4;
    localparam int LOG_N = 20000;

    typedef struct {
        int          cyc;
        logic [49:0] w;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [CW:0] context_max_id_in = '0;
    logic [15:0] exec_cycles = '0;
    logic        abort = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_input_index_1 = '0;
    logic [2:0]  cfg_input_index_2 = '0;
    logic [3:0]  cfg_op = '0;
    logic [31:0] cfg_const = '0;
    logic [1:0]  config_PE_row_index;
    logic [1:0]  config_PE_column_index;
    logic [3:0]  config_index;
    logic [2:0]  config_input_PE_index_1;
    logic [2:0]  config_input_PE_index_2;
    logic [3:0]  config_op;
    logic [31:0] config_const_data;
    logic        write_config_data;
    logic        start_exec;
    logic [3:0]  mapping_context_max_id;
    logic        busy;
    logic        done;
    logic        error;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  busy_log [LOG_N];
    bit  rdy_log  [LOG_N];
    wr_t exp_w [$];
    wr_t obs_w [$];
    int  obs_s [$];
    int  obs_d [$];
    int  obs_e [$];

    logic [59:0] all_outs;
    assign all_outs = {cfg_ready, config_PE_row_index, config_PE_column_index, config_index,
                       config_input_PE_index_1, config_input_PE_index_2, config_op,
                       config_const_data, write_config_data, start_exec,
                       mapping_context_max_id, busy, done, error};

    cgra_config_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .load_start              (load_start),
        .context_max_id_in       (context_max_id_in),
        .exec_cycles             (exec_cycles),
        .abort                   (abort),
        .cfg_valid               (cfg_valid),
        .cfg_ready               (cfg_ready),
        .cfg_input_index_1       (cfg_input_index_1),
        .cfg_input_index_2       (cfg_input_index_2),
        .cfg_op                  (cfg_op),
        .cfg_const               (cfg_const),
        .config_PE_row_index     (config_PE_row_index),
        .config_PE_column_index  (config_PE_column_index),
        .config_index            (config_index),
        .config_input_PE_index_1 (config_input_PE_index_1),
        .config_input_PE_index_2 (config_input_PE_index_2),
        .config_op               (config_op),
        .config_const_data       (config_const_data),
        .write_config_data       (write_config_data),
        .start_exec              (start_exec),
        .mapping_context_max_id  (mapping_context_max_id),
        .busy                    (busy),
        .done                    (done),
        .error                   (error)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // cycle index: cycle c is the interval after the c-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [49:0] pack_w(input logic [3:0] c, input logic [1:0] r,
                                           input logic [1:0] cl, input logic [2:0] i1,
                                           input logic [2:0] i2, input logic [3:0] op,
                                           input logic [31:0] d);
        return {c, r, cl, i1, i2, op, d};
    endfunction

    // event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            busy_log[cyc] = busy;
            rdy_log[cyc]  = cfg_ready;
        end
        if (write_config_data)
            obs_w.push_back('{cyc: cyc,
                              w: pack_w(config_index, config_PE_row_index, config_PE_column_index,
                                        config_input_PE_index_1, config_input_PE_index_2,
                                        config_op, config_const_data)});
        if (start_exec) obs_s.push_back(cyc);
        if (done)       obs_d.push_back(cyc);
        if (error)      obs_e.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_writes();
        check_eq("wr_count", 64'(obs_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            check_eq($sformatf("wr%0d_cyc", i), 64'(obs_w[i].cyc), 64'(exp_w[i].cyc));
            check_eq($sformatf("wr%0d_dat", i), 64'(obs_w[i].w), 64'(exp_w[i].w));
        end
    endtask

    // One load-and-run transaction. mode: 0 valid always, 1 toggling, 2 random.
    // cut_after >= 0 aborts (or resets) once that many words were accepted.
    task automatic run_txn(input int max_id, input int exec_n, input int mode, input bit seq_fields,
                           input int cut_after, input bit cut_is_reset, input bit poke);
        int  n_words;
        int  k;
        int  budget;
        int  last_hs;
        int  s_exp;
        int  d_exp;
        int  d;
        int  run_len;
        bit  v;
        exp_w.delete(); obs_w.delete(); obs_s.delete(); obs_d.delete();
        n_words = (max_id + 1) * ROWS * COLS;
        run_len = (exec_n == 0) ? 1 : exec_n;
        @(negedge clk);
        load_start        = 1'b1;
        context_max_id_in = (CW+1)'(max_id);
        exec_cycles       = 16'(exec_n);
        @(negedge clk);
        load_start = 1'b0;
        check_eq("rdy_after_ls", 64'(cfg_ready), 64'd1);
        check_eq("busy_after_ls", 64'(busy), 64'd1);
        k = 0; budget = 0; last_hs = 0;
        while (k < n_words && budget < 4000) begin
            if (cut_after >= 0 && k == cut_after) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            cfg_valid         = v;
            cfg_input_index_1 = 3'($urandom);
            cfg_input_index_2 = 3'($urandom);
            cfg_op            = seq_fields ? 4'(k) : 4'($urandom);
            cfg_const         = seq_fields ? 32'(k) : $urandom;
            if (v && cfg_ready) begin
                exp_w.push_back('{cyc: cyc + 1,
                                  w: pack_w(4'(k / (ROWS * COLS)), 2'((k / COLS) % ROWS), 2'(k % COLS),
                                            cfg_input_index_1, cfg_input_index_2, cfg_op, cfg_const)});
                last_hs = cyc;
                k++;
            end
            @(negedge clk);
            budget++;
        end
        if (cut_after >= 0) begin
            if (cut_is_reset) reset = 1'b1; else abort = 1'b1;
            cfg_valid = 1'b1;
            @(negedge clk);
            reset = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
            check_eq("cut_rdy", 64'(cfg_ready), 64'd0);
            check_eq("cut_busy", 64'(busy), 64'd0);
            check_eq("cut_wr", 64'(write_config_data), 64'd0);
            if (cut_is_reset) check_eq("rst_outs", 64'(all_outs), 64'd0);
            repeat (20) @(negedge clk);
            check_eq("cut_no_start", 64'(obs_s.size()), 64'd0);
            check_eq("cut_no_done", 64'(obs_d.size()), 64'd0);
            compare_writes();
            return;
        end
        cfg_valid = 1'b0;
        check_eq("load_words", 64'(k), 64'(n_words));
        if (poke) begin
            load_start        = 1'b1;
            context_max_id_in = (CW+1)'($urandom_range(0, 15));
            @(negedge clk);
            @(negedge clk);
            load_start = 1'b0;
        end
        budget = 0;
        while (obs_d.size() == 0 && budget < run_len + 40) begin
            @(negedge clk);
            budget++;
        end
        if (obs_d.size() == 0) check_eq("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        s_exp = last_hs + 2;
        d_exp = s_exp + run_len + 1;
        compare_writes();
        check_eq("rdy_drop", 64'(rdy_log[last_hs + 1]), 64'd0);
        check_eq("start_count", 64'(obs_s.size()), 64'd1);
        if (obs_s.size() > 0) check_eq("start_cyc", 64'(obs_s[0]), 64'(s_exp));
        check_eq("done_count", 64'(obs_d.size()), 64'd1);
        if (obs_d.size() > 0) begin
            d = obs_d[0];
            check_eq("done_cyc", 64'(d), 64'(d_exp));
            check_eq("busy_at_done", 64'(busy_log[d]), 64'd1);
            check_eq("busy_after_done", 64'(busy_log[d + 1]), 64'd0);
            check_eq("rdy_after_done", 64'(rdy_log[d + 1]), 64'd0);
        end
        check_eq("map_max_id", 64'(mapping_context_max_id), 64'(max_id));
    endtask

    initial begin
        int t;
        int ne;
        // reset state
        repeat (3) @(negedge clk);
        check_eq("reset_outs", 64'(all_outs), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_outs", 64'(all_outs), 64'd0);

        // single context, sequential fields
        run_txn(0, 5, 0, 1'b1, -1, 1'b0, 1'b0);
        // three contexts, cfg_valid toggling
        run_txn(2, int'($urandom_range(1, 12)), 1, 1'b0, -1, 1'b0, 1'b0);

        // out-of-range context id is rejected
        ne = obs_e.size();
        @(negedge clk);
        load_start        = 1'b1;
        context_max_id_in = (CW+1)'(16 + $urandom_range(0, 15));
        t = cyc;
        @(negedge clk);
        load_start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("err_count", 64'(obs_e.size() - ne), 64'd1);
        if (obs_e.size() > ne) check_eq("err_cyc", 64'(obs_e[ne]), 64'(t + 1));
        check_eq("err_busy1", 64'(busy_log[t + 1]), 64'd0);
        check_eq("err_busy2", 64'(busy_log[t + 2]), 64'd0);
        check_eq("err_rdy", 64'(rdy_log[t + 1]), 64'd0);

        // abort after word 7, then a clean restart
        run_txn(1, 3, 0, 1'b0, 7, 1'b0, 1'b0);
        run_txn(0, 2, 0, 1'b0, -1, 1'b0, 1'b0);
        // zero run length with load_start poked during START/RUN
        run_txn(0, 0, 0, 1'b0, -1, 1'b0, 1'b1);
        // reset in the middle of a load
        run_txn(1, 4, 2, 1'b0, 10, 1'b1, 1'b0);
        // random transactions
        for (int i = 0; i < 3; i++)
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 2, 1'b0, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
